keypad_scan_ctrl: RTL and testbench

Scan sequencer for the 4x4 matrix keypad. It drives the row lines one at a time and samples the column lines. It debounces both press and release and rejects ghost patterns. Each accepted key is delivered as a 4-bit hex code over a valid/ready handshake to the downstream digit-entry and 7-segment display logic.

---
 rtl/keypad_pkg.sv | 46 ++++
 rtl/keypad_tick_div.sv | 28 ++
 rtl/keypad_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map,
// row/column idle patterns and small pattern-decoding helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_HASH  = 4'hF;
    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_NONE  = 4'b1111;

    // Indexed [row][col]; '*' and '#' are folded into the unused hex codes E and F.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1,     4'h2, 4'h3,     4'hA},
        '{4'h4,     4'h5, 4'h6,     4'hB},
        '{4'h7,     4'h8, 4'h9,     4'hC},
        '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
    };

    function automatic logic [3:0] rowDrive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Exactly one low column is a usable key; several lows indicate ghosting.
    function automatic logic colSingle(input logic [3:0] pattern);
        case (pattern)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] colIndex(input logic [3:0] pattern);
        case (pattern)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_tick_div.sv
// Row dwell counter: one sample tick every SCAN_DIV clocks, restarted by a
// synchronous clear.
module keypad_tick_div #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic i_clear,
    output logic o_tick
);

    localparam int             DW   = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]  LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + DW'(1);
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan sequencer: row scanning, press/release debounce, ghost
// rejection and a valid/ready key-code output with overrun reporting.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun
);

    localparam int            CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

    state_t        r_state;
    logic [1:0]    r_rowIdx;
    logic [1:0]    r_colIdx;
    logic [3:0]    r_row;
    logic [3:0]    r_pat;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_keyCode;
    logic          r_keyValid;
    logic          r_keyDown;
    logic          r_overrun;

    logic          w_tick;
    logic [CW-1:0] w_cntNext;
    logic          w_colValid;
    logic [1:0]    w_colIdx;
    logic          w_transfer;
    logic          w_accept;
    logic [3:0]    w_acceptCode;

    keypad_tick_div #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tickDiv (
        .clk     (clk),
        .i_clear (rst),
        .o_tick  (w_tick)
    );

    // The accept decision is shared by the handshake and FSM sections below.
    always_comb begin
        w_cntNext    = r_cnt + CW'(1);
        w_colValid   = colSingle(col);
        w_colIdx     = colIndex(col);
        w_transfer   = r_keyValid && key_ready;
        w_accept     = 1'b0;
        w_acceptCode = KEYMAP[r_rowIdx][r_colIdx];
        if (w_tick) begin
            if (r_state == IDLE && w_colValid && DEBOUNCE_SCANS == 1) begin
                w_accept     = 1'b1;
                w_acceptCode = KEYMAP[r_rowIdx][w_colIdx];
            end else if (r_state == DEBOUNCE && col == r_pat && w_cntNext == CNT_DONE) begin
                w_accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rowIdx   <= '0;
            r_colIdx   <= '0;
            r_row      <= ROW_RESET;
            r_pat      <= COL_NONE;
            r_cnt      <= '0;
            r_keyCode  <= '0;
            r_keyValid <= 1'b0;
            r_keyDown  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            // A new key may replace the pending one only if it leaves this cycle.
            if (w_accept) begin
                if (!r_keyValid || key_ready) begin
                    r_keyValid <= 1'b1;
                    r_keyCode  <= w_acceptCode;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_transfer) begin
                r_keyValid <= 1'b0;
            end

            if (w_tick) begin
                unique case (r_state)
                    IDLE: begin
                        if (w_colValid) begin
                            r_colIdx <= w_colIdx;
                            r_pat    <= col;
                            r_cnt    <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state   <= PRESSED;
                                r_keyDown <= 1'b1;
                            end else begin
                                r_state <= DEBOUNCE;
                            end
                        end else begin
                            r_rowIdx <= r_rowIdx + 2'd1;
                            r_row    <= rowDrive(r_rowIdx + 2'd1);
                        end
                    end
                    DEBOUNCE: begin
                        if (col == r_pat) begin
                            r_cnt <= w_cntNext;
                            if (w_cntNext == CNT_DONE) begin
                                r_state   <= PRESSED;
                                r_keyDown <= 1'b1;
                            end
                        end else begin
                            r_state  <= IDLE;
                            r_rowIdx <= r_rowIdx + 2'd1;
                            r_row    <= rowDrive(r_rowIdx + 2'd1);
                        end
                    end
                    PRESSED: begin
                        if (col == COL_NONE) begin
                            r_cnt <= CW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state   <= IDLE;
                                r_keyDown <= 1'b0;
                                r_rowIdx  <= r_rowIdx + 2'd1;
                                r_row     <= rowDrive(r_rowIdx + 2'd1);
                            end else begin
                                r_state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        // Any low column means the key bounced back down; no new key is produced.
                        if (col == COL_NONE) begin
                            r_cnt <= w_cntNext;
                            if (w_cntNext == CNT_DONE) begin
                                r_state   <= IDLE;
                                r_keyDown <= 1'b0;
                                r_rowIdx  <= r_rowIdx + 2'd1;
                                r_row     <= rowDrive(r_rowIdx + 2'd1);
                            end
                        end else begin
                            r_state <= PRESSED;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign row       = r_row;
    assign key_code  = r_keyCode;
    assign key_valid = r_keyValid;
    assign key_down  = r_keyDown;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: directed step table plus randomized
// key/ready activity compared every cycle against a behavioural keypad model.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    localparam logic [3:0] KEY_HEX [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    typedef struct {
        int         cycles;
        logic       rst;
        logic       ready;
        logic [15:0] keys;
        logic [3:0] expRow;
        logic       expValid;
        logic [3:0] expCode;
        logic       expDown;
        logic       expOver;
    } stepRec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  keyCode;
    logic        keyValid;
    logic        keyReady;
    logic        keyDown;
    logic        overrun;
    logic [15:0] keys;

    int vectors = 0;
    int miscompares = 0;

    int         mDiv, mRow, mKey, mStreak;
    bit         mLocked, mHeld, mPend, mOver, mAccept, modelLive;
    logic [3:0] mCode;
    logic [3:0] mPat;

    stepRec_t steps[$];

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (keyCode),
        .key_valid (keyValid),
        .key_ready (keyReady),
        .key_down  (keyDown),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a held key pulls its column low whenever its row is driven.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4 + c]) col[c] = 1'b0;
                end
            end
        end
    end

    function automatic int zeroPos(input logic [3:0] p);
        for (int c = 0; c < 4; c++) if (!p[c]) return c;
        return 0;
    endfunction

    function automatic logic [3:0] rowOf(input int idx);
        logic [3:0] v;
        v = 4'b1111;
        v[idx] = 1'b0;
        return v;
    endfunction

    // Reference model: scan position, lock/held flags and a streak of agreeing samples.
    task automatic modelStep();
        if (rst) begin
            mDiv = 0; mRow = 0; mKey = 0; mStreak = 0;
            mLocked = 0; mHeld = 0; mPend = 0; mOver = 0; mCode = 4'h0;
            modelLive = 1;
        end else begin
            mAccept = 0;
            mOver   = 0;
            if (mDiv == SCAN_DIV - 1) begin
                if (!mLocked) begin
                    if ($countones(~col) == 1) begin
                        mLocked = 1;
                        mKey    = mRow * 4 + zeroPos(col);
                        mStreak = 1;
                        if (mStreak == DEBOUNCE_SCANS) begin
                            mAccept = 1; mHeld = 1; mStreak = 0;
                        end
                    end else begin
                        mRow = (mRow + 1) % 4;
                    end
                end else if (!mHeld) begin
                    mPat = 4'b1111;
                    mPat[mKey % 4] = 1'b0;
                    if (col == mPat) begin
                        mStreak++;
                        if (mStreak == DEBOUNCE_SCANS) begin
                            mAccept = 1; mHeld = 1; mStreak = 0;
                        end
                    end else begin
                        mLocked = 0;
                        mRow = (mRow + 1) % 4;
                    end
                end else begin
                    if (col == 4'b1111) begin
                        mStreak++;
                        if (mStreak == DEBOUNCE_SCANS) begin
                            mHeld = 0; mLocked = 0; mStreak = 0;
                            mRow = (mRow + 1) % 4;
                        end
                    end else begin
                        mStreak = 0;
                    end
                end
            end
            if (mAccept) begin
                if (!mPend || keyReady) begin
                    mPend = 1;
                    mCode = KEY_HEX[mKey];
                end else begin
                    mOver = 1;
                end
            end else if (mPend && keyReady) begin
                mPend = 0;
            end
            mDiv = (mDiv + 1) % SCAN_DIV;
        end
    endtask

    task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got row=%b valid=%b code=%h down=%b ovr=%b, expected row=%b valid=%b code=%h down=%b ovr=%b",
                     name, $time, act[10:7], act[6], act[5:2], act[1], act[0],
                     exp[10:7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [10:0] actualVec();
        return {row, keyValid, keyValid ? keyCode : 4'h0, keyDown, overrun};
    endfunction

    initial begin
        modelLive = 0;
        forever @(posedge clk) modelStep();
    end

    // Cycle-by-cycle comparison against the model once it has seen a reset.
    initial begin
        forever begin
            @(negedge clk);
            if (modelLive) begin
                checkOutput("model", actualVec(),
                            {rowOf(mRow), mPend, mPend ? mCode : 4'h0, mHeld, mOver});
            end
        end
    end

    task automatic applyStimulus(input stepRec_t s, input int idx);
        rst      = s.rst;
        keyReady = s.ready;
        keys     = s.keys;
        repeat (s.cycles) @(negedge clk);
        checkOutput($sformatf("step%0d", idx), actualVec(),
                    {s.expRow, s.expValid, s.expValid ? s.expCode : 4'h0, s.expDown, s.expOver});
    endtask

    initial begin
        rst      = 1'b1;
        keyReady = 1'b0;
        keys     = 16'h0000;

        // Reset and idle scanning.
        steps.push_back('{2,  1'b1, 1'b0, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{3,  1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{1,  1'b0, 1'b0, 16'h0000, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{4,  1'b0, 1'b0, 16'h0000, 4'b1011, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{4,  1'b0, 1'b0, 16'h0000, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{4,  1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{48, 1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        // Press row1/col2 with ready high, then release.
        steps.push_back('{12, 1'b0, 1'b1, 16'h0040, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{3,  1'b0, 1'b1, 16'h0040, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{1,  1'b0, 1'b1, 16'h0040, 4'b1101, 1'b1, 4'h6, 1'b1, 1'b0});
        steps.push_back('{1,  1'b0, 1'b1, 16'h0040, 4'b1101, 1'b0, 4'h0, 1'b1, 1'b0});
        steps.push_back('{10, 1'b0, 1'b1, 16'h0000, 4'b1101, 1'b0, 4'h0, 1'b1, 1'b0});
        steps.push_back('{1,  1'b0, 1'b1, 16'h0000, 4'b1011, 1'b0, 4'h0, 1'b0, 1'b0});
        // Bounce on row2/col0 for a single sample.
        steps.push_back('{5,  1'b0, 1'b1, 16'h0100, 4'b1011, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{3,  1'b0, 1'b1, 16'h0000, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{4,  1'b0, 1'b1, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        // Ghost pattern 0011 on row0.
        steps.push_back('{4,  1'b0, 1'b1, 16'h000C, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{8,  1'b0, 1'b1, 16'h000C, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0});
        // Ready low: key 0 stays pending, second key overruns, then transfer.
        steps.push_back('{12, 1'b0, 1'b0, 16'h2000, 4'b0111, 1'b1, 4'h0, 1'b1, 1'b0});
        steps.push_back('{12, 1'b0, 1'b0, 16'h0000, 4'b1110, 1'b1, 4'h0, 1'b0, 1'b0});
        steps.push_back('{20, 1'b0, 1'b0, 16'h0200, 4'b1011, 1'b1, 4'h0, 1'b1, 1'b1});
        steps.push_back('{1,  1'b0, 1'b0, 16'h0200, 4'b1011, 1'b1, 4'h0, 1'b1, 1'b0});
        steps.push_back('{1,  1'b0, 1'b1, 16'h0200, 4'b1011, 1'b0, 4'h0, 1'b1, 1'b0});
        // Reset while PRESSED with a key pending.
        steps.push_back('{10, 1'b0, 1'b0, 16'h0000, 4'b0111, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{12, 1'b0, 1'b0, 16'h8000, 4'b0111, 1'b1, 4'hD, 1'b1, 1'b0});
        steps.push_back('{1,  1'b1, 1'b0, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{3,  1'b0, 1'b0, 16'h0000, 4'b1110, 1'b0, 4'h0, 1'b0, 1'b0});
        steps.push_back('{1,  1'b0, 1'b0, 16'h0000, 4'b1101, 1'b0, 4'h0, 1'b0, 1'b0});

        for (int i = 0; i < steps.size(); i++) begin
            applyStimulus(steps[i], i);
        end

        // Randomized key activity; the model checker judges every cycle.
        for (int seg = 0; seg < 300; seg++) begin
            int pick;
            pick = $urandom_range(0, 99);
            rst = (pick < 2);
            if (pick < 45)       keys = 16'h0000;
            else if (pick < 88)  keys = 16'h0001 << $urandom_range(0, 15);
            else                 keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            keyReady = ($urandom_range(0, 1) == 1);
            if (rst) begin
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
